// File: rtl/bayer_demosaic_param_if.sv
// bayer_demosaic_param_if: pixel input, per-colour frame-memory ports and done flag.
interface bayer_demosaic_param_if #(parameter int DW = 8, parameter int XW = 7, parameter int YW = 7);
  logic in_en;
  logic [DW-1:0] data_in;
  logic [1:0] cfa_mode;
  logic wr_r, wr_g, wr_b;
  logic [XW+YW-1:0] addr_r, addr_g, addr_b;
  logic [DW-1:0] wdata_r, wdata_g, wdata_b;
  logic [DW-1:0] rdata_r, rdata_g, rdata_b;
  logic done;
  modport master (
    input in_en, data_in, cfa_mode, rdata_r, rdata_g, rdata_b,
    output wr_r, wr_g, wr_b, addr_r, addr_g, addr_b, wdata_r, wdata_g, wdata_b, done
  );
  modport slave (
    output in_en, data_in, cfa_mode, rdata_r, rdata_g, rdata_b,
    input wr_r, wr_g, wr_b, addr_r, addr_g, addr_b, wdata_r, wdata_g, wdata_b, done
  );
endinterface

// File: rtl/bayer_demosaic_param.sv
// bayer_demosaic_param: loads a raw Bayer frame into R/G/B memories, then fills missing colours per pixel.
// Define DEMOSAIC_BORDER_EN to also process border pixels using mirrored neighbours.
module bayer_demosaic_param #(
  parameter int DW = 8,
  parameter int XW = 7,
  parameter int YW = 7
) (
  input logic clk,
  input logic reset,
  bayer_demosaic_param_if.master bus
);
  localparam int AW = XW + YW;
  localparam logic [XW-1:0] XMAX = '1;
  localparam logic [YW-1:0] YMAX = '1;
`ifdef DEMOSAIC_BORDER_EN
  localparam logic [XW-1:0] XLO = '0;
  localparam logic [XW-1:0] XHI = XMAX;
  localparam logic [YW-1:0] YLO = '0;
  localparam logic [YW-1:0] YHI = YMAX;
`else
  localparam logic [XW-1:0] XLO = XW'(1);
  localparam logic [XW-1:0] XHI = XMAX - 1'b1;
  localparam logic [YW-1:0] YLO = YW'(1);
  localparam logic [YW-1:0] YHI = YMAX - 1'b1;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, INIT, FETCH, CALC, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic [AW:0] r_cnt;
  logic [1:0] r_mode, r_rd_c, w_cc;
  logic [XW-1:0] r_row, w_nrow;
  logic [YW-1:0] r_col, w_ncol;
  logic [3:0] r_k;
  logic [DW-1:0] r_win [9];
  logic [2:0] r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wd_r, r_wd_g, r_wd_b, w_rd;
  logic [DW:0] w_sum_v, w_sum_h;
  logic [DW+1:0] w_sum_d, w_sum_x;
  logic [DW-1:0] w_avg_v, w_avg_h, w_avg_d, w_avg_x, w_dv, w_dh, w_g, w_val_r, w_val_b;
  logic w_hr, w_last;
  // 0=R, 1=G, 2=B; mode[1] flips which diagonal holds green, mode[0] picks the red row parity
  function automatic logic [1:0] colour(input logic [1:0] m, input logic pr, input logic pc);
    return ((pr ^ pc) != m[1]) ? 2'd1 : (pr == m[0]) ? 2'd0 : 2'd2;
  endfunction
  // Neighbour k (row-major 3x3) of (row,col), reflected at the image edge
  function automatic logic [AW-1:0] nb_addr(input logic [XW-1:0] row, input logic [YW-1:0] col,
                                            input logic [3:0] k);
    logic [XW-1:0] rr;
    logic [YW-1:0] cc;
    rr = (k < 4'd3) ? ((row == '0) ? XW'(1) : row - 1'b1) :
         (k > 4'd5) ? ((row == XMAX) ? XMAX - 1'b1 : row + 1'b1) : row;
    cc = (k == 4'd0 || k == 4'd3 || k == 4'd6) ? ((col == '0) ? YW'(1) : col - 1'b1) :
         (k == 4'd2 || k == 4'd5 || k == 4'd8) ? ((col == YMAX) ? YMAX - 1'b1 : col + 1'b1) : col;
    return {rr, cc};
  endfunction
  assign w_rd = (r_rd_c == 2'd0) ? bus.rdata_r : (r_rd_c == 2'd1) ? bus.rdata_g : bus.rdata_b;
  assign w_sum_v = r_win[1] + r_win[7];
  assign w_sum_h = r_win[3] + r_win[5];
  assign w_sum_d = r_win[0] + r_win[2] + r_win[6] + r_win[8];
  assign w_sum_x = w_sum_v + w_sum_h;
  assign w_avg_v = DW'((w_sum_v + 1'b1) >> 1);
  assign w_avg_h = DW'((w_sum_h + 1'b1) >> 1);
  assign w_avg_d = DW'((w_sum_d + 2'd2) >> 2);
  assign w_avg_x = DW'((w_sum_x + 2'd2) >> 2);
  assign w_dv = (r_win[1] > r_win[7]) ? r_win[1] - r_win[7] : r_win[7] - r_win[1];
  assign w_dh = (r_win[3] > r_win[5]) ? r_win[3] - r_win[5] : r_win[5] - r_win[3];
  assign w_g = (w_dv < w_dh) ? w_avg_v : (w_dh < w_dv) ? w_avg_h : w_avg_x;
  assign w_cc = colour(r_mode, r_row[0], r_col[0]);
  assign w_hr = r_row[0] == r_mode[0];
  assign w_val_r = (w_cc == 2'd1) ? (w_hr ? w_avg_h : w_avg_v) : w_avg_d;
  assign w_val_b = (w_cc == 2'd1) ? (w_hr ? w_avg_v : w_avg_h) : w_avg_d;
  assign w_last = (r_row == XHI) && (r_col == YHI);
  assign w_ncol = (r_col == YHI) ? YLO : r_col + 1'b1;
  assign w_nrow = (r_col == YHI) ? r_row + 1'b1 : r_row;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.in_en ? LOAD : IDLE;
      LOAD:    w_next = r_cnt[AW] ? INIT : LOAD;
      INIT:    w_next = FETCH;
      FETCH:   w_next = (r_k == 4'd9) ? CALC : FETCH;
      CALC:    w_next = WRITE;
      WRITE:   w_next = w_last ? DONE : FETCH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      r_mode <= '0;
      r_rd_c <= '0;
      r_row <= '0;
      r_col <= '0;
      r_k <= '0;
      r_win <= '{default: '0};
      r_wr <= '0;
      r_addr <= '0;
      r_wd_r <= '0;
      r_wd_g <= '0;
      r_wd_b <= '0;
    end else begin
      r_wr <= '0;
      // colour of the address now on the bus, aligned with its read data next cycle
      r_rd_c <= colour(r_mode, r_addr[YW], r_addr[0]);
      case (r_state)
        IDLE: if (bus.in_en) begin
          r_mode <= bus.cfa_mode;
          r_cnt <= (AW+1)'(1);
          r_wr <= 3'b001 << colour(bus.cfa_mode, 1'b0, 1'b0);
          r_addr <= '0;
          {r_wd_r, r_wd_g, r_wd_b} <= {3{bus.data_in}};
        end
        LOAD: if (bus.in_en && !r_cnt[AW]) begin
          r_cnt <= r_cnt + 1'b1;
          r_wr <= 3'b001 << colour(r_mode, r_cnt[YW], r_cnt[0]);
          r_addr <= r_cnt[AW-1:0];
          {r_wd_r, r_wd_g, r_wd_b} <= {3{bus.data_in}};
        end
        INIT: begin
          r_row <= XLO;
          r_col <= YLO;
          r_k <= '0;
          r_addr <= nb_addr(XLO, YLO, 4'd0);
        end
        FETCH: begin
          r_k <= r_k + 1'b1;
          if (r_k < 4'd8) r_addr <= nb_addr(r_row, r_col, r_k + 1'b1);
          if (r_k != 4'd0) r_win[r_k - 1'b1] <= w_rd;
        end
        CALC: begin
          r_wr <= ~(3'b001 << w_cc);
          r_addr <= {r_row, r_col};
          r_wd_r <= w_val_r;
          r_wd_g <= w_g;
          r_wd_b <= w_val_b;
        end
        WRITE: begin
          r_row <= w_nrow;
          r_col <= w_ncol;
          r_k <= '0;
          r_addr <= nb_addr(w_nrow, w_ncol, 4'd0);
        end
        default: ;
      endcase
    end
  assign bus.wr_r = r_wr[0];
  assign bus.wr_g = r_wr[1];
  assign bus.wr_b = r_wr[2];
  assign bus.addr_r = r_addr;
  assign bus.addr_g = r_addr;
  assign bus.addr_b = r_addr;
  assign bus.wdata_r = r_wd_r;
  assign bus.wdata_g = r_wd_g;
  assign bus.wdata_b = r_wd_b;
  assign bus.done = r_state == DONE;
endmodule

// File: tb/tb_bayer_demosaic_param.sv
// tb_bayer_demosaic_param: 8x8 frames through the demosaicer with R/G/B memory models,
// checked against a pattern-table reference model (honours DEMOSAIC_BORDER_EN).
module tb_bayer_demosaic_param;
  localparam int W = 8;
  localparam int NPIX = 64;
`ifdef DEMOSAIC_BORDER_EN
  localparam int LO = 0, HI = 7, SITES = 64;
`else
  localparam int LO = 1, HI = 6, SITES = 36;
`endif
  logic clk = 0, reset = 0;
  int n_checks = 0, n_fail = 0;
  int done_cnt, bad_wr;
  int wc [3][64];
  logic [7:0] mem [3][64];
  int img [64];
  int ex [3][64];
  int ew [3][64];
  string pats [4] = '{"RGGB", "BGGR", "GRBG", "GBRG"};

  bayer_demosaic_param_if #(.DW(8), .XW(3), .YW(3)) bus ();
  bayer_demosaic_param #(.DW(8), .XW(3), .YW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.wr_r) begin mem[0][bus.addr_r] <= bus.wdata_r; wc[0][bus.addr_r]++; end
    if (bus.wr_g) begin mem[1][bus.addr_g] <= bus.wdata_g; wc[1][bus.addr_g]++; end
    if (bus.wr_b) begin mem[2][bus.addr_b] <= bus.wdata_b; wc[2][bus.addr_b]++; end
    if (bus.wr_r && bus.wr_g && bus.wr_b) bad_wr++;
    if (bus.done) done_cnt++;
    bus.rdata_r <= mem[0][bus.addr_r];
    bus.rdata_g <= mem[1][bus.addr_g];
    bus.rdata_b <= mem[2][bus.addr_b];
  end

  function automatic int cidx(int mode, int r, int c);
    string p = pats[mode];
    byte ch = p[(r % 2) * 2 + (c % 2)];
    return (ch == "R") ? 0 : (ch == "G") ? 1 : 2;
  endfunction

  function automatic int px(int r, int c);
    if (r < 0) r = -r;
    if (r > W - 1) r = 2 * (W - 1) - r;
    if (c < 0) c = -c;
    if (c > W - 1) c = 2 * (W - 1) - c;
    return img[r * W + c];
  endfunction

  task automatic model_frame(input int mode);
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        int a, nat;
        a = r * W + c;
        nat = cidx(mode, r, c);
        for (int k = 0; k < 3; k++) begin ew[k][a] = 0; ex[k][a] = 0; end
        ew[nat][a] = 1;
        ex[nat][a] = img[a];
        if (r >= LO && r <= HI && c >= LO && c <= HI) begin
          int n, s, w, e, d, dv, dh, hc;
          n = px(r - 1, c); s = px(r + 1, c); w = px(r, c - 1); e = px(r, c + 1);
          d = px(r - 1, c - 1) + px(r - 1, c + 1) + px(r + 1, c - 1) + px(r + 1, c + 1);
          if (nat == 1) begin
            hc = cidx(mode, r, c + 1);
            ex[hc][a] = (w + e + 1) / 2;
            ex[2 - hc][a] = (n + s + 1) / 2;
            ew[hc][a] = 1;
            ew[2 - hc][a] = 1;
          end else begin
            dv = (n > s) ? n - s : s - n;
            dh = (w > e) ? w - e : e - w;
            ex[2 - nat][a] = (d + 2) / 4;
            ex[1][a] = (dv < dh) ? (n + s + 1) / 2 : (dh < dv) ? (w + e + 1) / 2 : (n + s + w + e + 2) / 4;
            ew[2 - nat][a] = 1;
            ew[1][a] = 1;
          end
        end
      end
  endtask

  // gap: 0 none, 1 idle cycle before every pixel, 2 random idle cycles
  task automatic load_frame(input int mode, input int gap);
    foreach (wc[c, a]) wc[c][a] = 0;
    done_cnt = 0;
    bad_wr = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        bus.in_en = 0;
        bus.data_in = 8'($urandom);
        @(posedge clk); #1;
      end
      bus.in_en = 1;
      bus.data_in = 8'(img[i]);
      bus.cfa_mode = (i == 0) ? 2'(mode) : 2'($urandom);
      @(posedge clk); #1;
    end
    bus.in_en = 0;
  endtask

  task automatic wait_done(output bit to);
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin to = 0; break; end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 0;
    bus.in_en = 0; bus.data_in = 0; bus.cfa_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.wr_r, bus.wr_g, bus.wr_b, bus.done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {bus.wr_r, bus.wr_g, bus.wr_b, bus.done});
    end
    n_checks++;
    if ({bus.addr_r, bus.addr_g, bus.addr_b} !== 18'b0) begin
      n_fail++; $display("FAIL reset_addr got %h exp 0", {bus.addr_r, bus.addr_g, bus.addr_b});
    end
    n_checks++;
    if ({bus.wdata_r, bus.wdata_g, bus.wdata_b} !== 24'b0) begin
      n_fail++; $display("FAIL reset_wdata got %h exp 0", {bus.wdata_r, bus.wdata_g, bus.wdata_b});
    end
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_flat;
    bit to;
    int tot;
    foreach (img[i]) img[i] = 100;
    load_frame(0, 0);
    wait_done(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL flat_timeout got no done exp done"); end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL flat_done_pulses got %0d exp 1", done_cnt); end
    tot = 0;
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < NPIX; a++)
        if (wc[c][a] > 0) begin
          tot += wc[c][a];
          n_checks++;
          if (mem[c][a] !== 8'd100) begin
            n_fail++; $display("FAIL flat_value c%0d a%0d got %0d exp 100", c, a, mem[c][a]);
          end
        end
    n_checks++;
    if (tot !== NPIX + 2 * SITES) begin
      n_fail++; $display("FAIL flat_write_total got %0d exp %0d", tot, NPIX + 2 * SITES);
    end
  endtask

  task automatic test_directed;
    bit to;
    foreach (img[i]) img[i] = $urandom_range(0, 255);
    img[18] = 10; img[20] = 21;
    img[28] = 50; img[44] = 50; img[35] = 10; img[37] = 90;
    img[14] = 40; img[30] = 40; img[21] = 40; img[23] = 40;
    load_frame(0, 2);
    wait_done(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL directed_timeout got no done exp done"); end
    n_checks++;
    if (mem[0][19] !== 8'd16) begin n_fail++; $display("FAIL g_site_round got %0d exp 16", mem[0][19]); end
    n_checks++;
    if (mem[1][36] !== 8'd50) begin n_fail++; $display("FAIL g_vertical got %0d exp 50", mem[1][36]); end
    n_checks++;
    if (mem[1][22] !== 8'd40) begin n_fail++; $display("FAIL g_four_avg got %0d exp 40", mem[1][22]); end
  endtask

  task automatic test_modes;
    for (int m = 0; m < 4; m++) begin
      bit to;
      int tot;
      foreach (img[i]) img[i] = $urandom_range(0, 255);
      model_frame(m);
      load_frame(m, (m % 2 == 1) ? 1 : (m == 0) ? 0 : 2);
      for (int i = 0; i < 60; i++) begin
        bus.in_en = 1'($urandom);
        bus.data_in = 8'($urandom);
        @(posedge clk); #1;
      end
      bus.in_en = 0;
      wait_done(to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL mode%0d_timeout got no done exp done", m); end
      n_checks++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL mode%0d_done_pulses got %0d exp 1", m, done_cnt); end
      n_checks++;
      if (bad_wr !== 0) begin n_fail++; $display("FAIL mode%0d_triple_write got %0d exp 0", m, bad_wr); end
      tot = 0;
      for (int c = 0; c < 3; c++)
        for (int a = 0; a < NPIX; a++) begin
          tot += wc[c][a];
          n_checks++;
          if (wc[c][a] !== ew[c][a]) begin
            n_fail++; $display("FAIL mode%0d_wcount c%0d a%0d got %0d exp %0d", m, c, a, wc[c][a], ew[c][a]);
          end
          if (ew[c][a] > 0) begin
            n_checks++;
            if (mem[c][a] !== 8'(ex[c][a])) begin
              n_fail++; $display("FAIL mode%0d_value c%0d a%0d got %0d exp %0d", m, c, a, mem[c][a], ex[c][a]);
            end
          end
        end
      n_checks++;
      if (tot !== NPIX + 2 * SITES) begin
        n_fail++; $display("FAIL mode%0d_write_total got %0d exp %0d", m, tot, NPIX + 2 * SITES);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    foreach (img[i]) img[i] = $urandom_range(0, 255);
    load_frame(1, 0);
    repeat (5) @(posedge clk);
    #2;
    reset = 0;
    #1;
    n_checks++;
    if ({bus.wr_r, bus.wr_g, bus.wr_b, bus.done} !== 4'b0) begin
      n_fail++; $display("FAIL midreset_flags got %b exp 0000", {bus.wr_r, bus.wr_g, bus.wr_b, bus.done});
    end
    n_checks++;
    if ({bus.addr_r, bus.addr_g, bus.addr_b, bus.wdata_r, bus.wdata_g, bus.wdata_b} !== 42'b0) begin
      n_fail++; $display("FAIL midreset_bus got %h exp 0",
                         {bus.addr_r, bus.addr_g, bus.addr_b, bus.wdata_r, bus.wdata_g, bus.wdata_b});
    end
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.wr_r, bus.wr_g, bus.wr_b} !== 3'b0) begin
      n_fail++; $display("FAIL release_write got %b exp 000", {bus.wr_r, bus.wr_g, bus.wr_b});
    end
    foreach (img[i]) img[i] = $urandom_range(0, 255);
    model_frame(3);
    load_frame(3, 0);
    wait_done(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL after_reset_timeout got no done exp done"); end
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < NPIX; a++) begin
        n_checks++;
        if (wc[c][a] !== ew[c][a] || (ew[c][a] > 0 && mem[c][a] !== 8'(ex[c][a]))) begin
          n_fail++; $display("FAIL after_reset_frame c%0d a%0d got %0d/%0d exp %0d/%0d",
                             c, a, wc[c][a], mem[c][a], ew[c][a], ex[c][a]);
        end
      end
  endtask

  initial begin
    test_reset;
    test_flat;
    test_directed;
    test_modes;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
